// File: rtl/trng_health_buffer_if.sv
// Handshake bundle between the TRNG generator, the health buffer and the
// key/nonce consumer. The buffer itself uses the slave view; whatever drives
// the generator and consumer sides uses the master view.
interface trng_health_buffer_if #(
  parameter int DATA_WIDTH = 256,
  parameter int DEPTH      = 4,
  parameter int FAIL_LIMIT = 3
);
  logic [DATA_WIDTH-1:0]         rnd_data_i;
  logic                          rnd_valid_i;
  logic                          trng_en_o;
  logic [DATA_WIDTH-1:0]         key_o;
  logic                          key_valid_o;
  logic                          key_ready_i;
  logic [$clog2(DEPTH):0]        level_o;
  logic [$clog2(FAIL_LIMIT):0]   fail_cnt_o;
  logic                          alarm_o;

  modport slave (
    input  rnd_data_i, rnd_valid_i, key_ready_i,
    output trng_en_o, key_o, key_valid_o, level_o, fail_cnt_o, alarm_o
  );

  modport master (
    output rnd_data_i, rnd_valid_i, key_ready_i,
    input  trng_en_o, key_o, key_valid_o, level_o, fail_cnt_o, alarm_o
  );
endinterface

// File: rtl/trng_health_buffer.sv
// Health-checked buffer for random words: one-word check stage (constant,
// repeat and ones-density tests) feeding a small circular FIFO. Throttles the
// generator so the FIFO can never overflow, and latches a sticky alarm after
// FAIL_LIMIT consecutive failing words, which silences all output until reset.
module trng_health_buffer #(
  parameter int DATA_WIDTH = 256,
  parameter int DEPTH      = 4,
  parameter int MIN_ONES   = 96,
  parameter int MAX_ONES   = 160,
  parameter int FAIL_LIMIT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  trng_health_buffer_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int FW = $clog2(FAIL_LIMIT) + 1;
  localparam int CW = $clog2(DATA_WIDTH) + 1;

  localparam logic [CW-1:0] MIN_PC  = CW'(MIN_ONES);
  localparam logic [CW-1:0] MAX_PC  = CW'(MAX_ONES);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [FW-1:0] LIMIT_F = FW'(FAIL_LIMIT);

  // FIFO storage: plain array, no reset needed since key_o is gated by level
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [DATA_WIDTH-1:0] check_reg;
  logic [DATA_WIDTH-1:0] prev_reg;
  logic                  pend_reg;
  logic                  prev_valid_reg;
  logic                  alarm_reg;
  logic [PW-1:0]         wr_ptr_reg;
  logic [PW-1:0]         rd_ptr_reg;
  logic [LW-1:0]         level_reg;
  logic [FW-1:0]         fail_cnt_reg;
  logic [FW-1:0]         fail_cnt_next;

  logic [CW-1:0] ones;
  logic [LW-1:0] occupancy;
  logic          word_bad;
  logic          retire;
  logic          push;
  logic          pop;
  logic          accept;
  logic          trng_en;
  logic          key_valid;
  logic          alarm_set;

  // The pending word already owns a FIFO slot, so it counts toward occupancy
  assign occupancy = level_reg + LW'(pend_reg);
  assign trng_en   = !alarm_reg && (occupancy < DEPTH_L);
  assign accept    = bus.rnd_valid_i && trng_en;
  assign key_valid = !alarm_reg && (level_reg != '0);
  assign pop       = key_valid && bus.key_ready_i;
  assign retire    = pend_reg && !alarm_reg;

  // Ones count of the word in the check register
  always_comb begin
    ones = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      ones = ones + CW'(check_reg[i]);
    end
  end

  // A single verdict per word, however many individual tests it trips
  assign word_bad = (check_reg == '0) || (check_reg == '1) ||
                    (prev_valid_reg && (check_reg == prev_reg)) ||
                    (ones < MIN_PC) || (ones > MAX_PC);
  assign push     = retire && !word_bad;

  // Consecutive-failure counter update and alarm trigger
  always_comb begin
    fail_cnt_next = fail_cnt_reg;
    alarm_set     = 1'b0;
    if (retire) begin
      if (word_bad) begin
        if (fail_cnt_reg < LIMIT_F) begin
          fail_cnt_next = fail_cnt_reg + FW'(1);
        end
        alarm_set = (fail_cnt_reg >= (LIMIT_F - FW'(1)));
      end else begin
        fail_cnt_next = '0;
      end
    end
  end

  assign bus.trng_en_o   = trng_en;
  assign bus.key_valid_o = key_valid;
  assign bus.key_o       = key_valid ? mem[rd_ptr_reg] : '0;
  assign bus.level_o     = level_reg;
  assign bus.fail_cnt_o  = fail_cnt_reg;
  assign bus.alarm_o     = alarm_reg;

  // Check stage: capture accepted word, retire it one cycle later, remember it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      check_reg      <= '0;
      pend_reg       <= 1'b0;
      prev_reg       <= '0;
      prev_valid_reg <= 1'b0;
    end else begin
      if (alarm_reg || alarm_set) begin
        pend_reg <= 1'b0;
      end else if (accept) begin
        check_reg <= bus.rnd_data_i;
        pend_reg  <= 1'b1;
      end else if (retire) begin
        pend_reg <= 1'b0;
      end
      if (retire) begin
        prev_reg       <= check_reg;
        prev_valid_reg <= 1'b1;
      end
    end
  end

  // FIFO write port
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= check_reg;
    end
  end

  // FIFO pointers and occupancy; the alarm flushes everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (alarm_reg || alarm_set) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      level_reg <= level_reg + LW'(push) - LW'(pop);
    end
  end

  // Failure counter and sticky alarm
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_cnt_reg <= '0;
      alarm_reg    <= 1'b0;
    end else begin
      fail_cnt_reg <= fail_cnt_next;
      alarm_reg    <= alarm_reg | alarm_set;
    end
  end

endmodule

// File: tb/tb_trng_health_buffer.sv
// Bench for trng_health_buffer: directed scenarios plus a randomized stream,
// all checked every cycle against a queue-based reference model.
module tb_trng_health_buffer;
  localparam int DW         = 256;
  localparam int DEPTH      = 4;
  localparam int MIN_ONES   = 96;
  localparam int MAX_ONES   = 160;
  localparam int FAIL_LIMIT = 3;

  logic clk;
  logic rst;

  trng_health_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FAIL_LIMIT(FAIL_LIMIT)) bus();

  trng_health_buffer #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .MIN_ONES(MIN_ONES),
    .MAX_ONES(MAX_ONES), .FAIL_LIMIT(FAIL_LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  bit            m_pend;
  logic [DW-1:0] m_check;
  logic [DW-1:0] m_prev;
  bit            m_prev_v;
  int            m_cnt;
  bit            m_alarm;
  bit            last_acc;
  logic [DW-1:0] last_gen;

  task automatic check(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_bad(logic [DW-1:0] w);
    int pc;
    pc = $countones(w);
    return (w == '0) || (&w) || (m_prev_v && (w == m_prev)) ||
           (pc < MIN_ONES) || (pc > MAX_ONES);
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    int pc;
    do begin
      for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom();
      pc = $countones(w);
    end while (pc < MIN_ONES || pc > MAX_ONES);
    return w;
  endfunction

  // Word with exactly k ones, randomly rotated
  function automatic logic [DW-1:0] pc_word(int k);
    logic [DW-1:0] w;
    int r;
    w = '0;
    for (int i = 0; i < k; i++) w[i] = 1'b1;
    r = $urandom_range(255, 1);
    return (w << r) | (w >> (DW - r));
  endfunction

  task automatic model_reset();
    q.delete();
    m_pend   = 0;
    m_check  = '0;
    m_prev   = '0;
    m_prev_v = 0;
    m_cnt    = 0;
    m_alarm  = 0;
    last_acc = 0;
  endtask

  task automatic compare_all();
    logic [DW-1:0] exp_key;
    bit exp_valid;
    exp_valid = !m_alarm && (q.size() > 0);
    exp_key   = exp_valid ? q[0] : '0;
    check("key_valid", DW'(bus.key_valid_o), DW'(exp_valid));
    check("key", bus.key_o, exp_key);
    check("level", DW'(bus.level_o), DW'(q.size()));
    check("fail_cnt", DW'(bus.fail_cnt_o), DW'(m_cnt));
    check("alarm", DW'(bus.alarm_o), DW'(m_alarm));
    check("trng_en", DW'(bus.trng_en_o),
          DW'(!m_alarm && (q.size() + int'(m_pend)) < DEPTH));
  endtask

  // One clock edge: advance the model with the inputs currently applied,
  // then compare every output just after the edge.
  task automatic tick();
    bit en, acc, pop, bad, alarm_now;
    logic [DW-1:0] tmp;
    en  = !m_alarm && (q.size() + int'(m_pend)) < DEPTH;
    acc = bus.rnd_valid_i && en;
    pop = !m_alarm && (q.size() > 0) && bus.key_ready_i;
    alarm_now = 0;
    if (pop) begin
      tmp = q.pop_front();
      $display("cycle %0d pop %h", cycle, tmp);
    end
    if (m_pend) begin
      bad = is_bad(m_check);
      m_prev   = m_check;
      m_prev_v = 1;
      if (!bad) begin
        q.push_back(m_check);
        m_cnt = 0;
      end else begin
        if (m_cnt < FAIL_LIMIT) m_cnt++;
        if (m_cnt == FAIL_LIMIT) alarm_now = 1;
      end
      $display("cycle %0d retire %h %s cnt=%0d", cycle, m_check, bad ? "drop" : "push", m_cnt);
    end
    m_pend = 0;
    if (acc) begin
      m_check = bus.rnd_data_i;
      m_pend  = 1;
    end
    if (alarm_now || m_alarm) begin
      m_alarm = 1;
      q.delete();
      m_pend = 0;
    end
    last_acc = acc;
    @(posedge clk);
    #1;
    cycle++;
    compare_all();
  endtask

  task automatic present(logic [DW-1:0] w, bit rdy);
    bus.rnd_data_i  = w;
    bus.rnd_valid_i = 1'b1;
    bus.key_ready_i = rdy;
    last_gen = w;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (last_acc) break;
    end
    check("accept_timeout", DW'(last_acc), DW'(1));
    bus.rnd_valid_i = 1'b0;
  endtask

  // Asynchronous reset applied mid-cycle; outputs checked before any edge
  task automatic apply_reset();
    #2;
    rst = 1'b1;
    bus.rnd_valid_i = 1'b0;
    bus.key_ready_i = 1'b0;
    #1;
    check("rst_trng_en", DW'(bus.trng_en_o), DW'(1));
    check("rst_key_valid", DW'(bus.key_valid_o), DW'(0));
    check("rst_key", bus.key_o, DW'(0));
    check("rst_level", DW'(bus.level_o), DW'(0));
    check("rst_fail_cnt", DW'(bus.fail_cnt_o), DW'(0));
    check("rst_alarm", DW'(bus.alarm_o), DW'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] w, w3, c55, c0f, ones;
    int r;
    rst = 1'b0;
    bus.rnd_data_i  = '0;
    bus.rnd_valid_i = 1'b0;
    bus.key_ready_i = 1'b0;
    c55 = {(DW/8){8'h55}};
    c0f = {(DW/8){8'h0f}};
    ones = '1;
    model_reset();
    apply_reset();

    // Single balanced word appears at the FIFO head one edge after capture
    present(c55, 1'b0);
    tick();
    check("bal_valid", DW'(bus.key_valid_o), DW'(1));
    check("bal_key", bus.key_o, c55);
    check("bal_fail_cnt", DW'(bus.fail_cnt_o), DW'(0));

    // Popcount boundaries with interleaved passing words
    present(pc_word(96), 1'b1);
    present(pc_word(160), 1'b1);
    present(pc_word(95), 1'b1);
    present(pc_word(161), 1'b1);
    present(rand_word(), 1'b1);
    present(pc_word(95), 1'b1);
    present(rand_word(), 1'b1);
    for (int i = 0; i < 4; i++) tick();
    check("bounds_alarm", DW'(bus.alarm_o), DW'(0));
    check("bounds_fail_cnt", DW'(bus.fail_cnt_o), DW'(0));

    // Fill the FIFO with the consumer stalled, then release one slot
    for (int i = 0; i < 4; i++) present(rand_word(), 1'b0);
    tick();
    bus.rnd_data_i  = rand_word();
    bus.rnd_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("full_trng_en", DW'(bus.trng_en_o), DW'(0));
    check("full_level", DW'(bus.level_o), DW'(4));
    bus.key_ready_i = 1'b1;
    tick();
    bus.key_ready_i = 1'b0;
    check("pop_trng_en", DW'(bus.trng_en_o), DW'(1));
    present(bus.rnd_data_i, 1'b0);
    tick();
    check("refill_level", DW'(bus.level_o), DW'(4));

    // Drain to level 2, then push and pop on the same edge
    bus.key_ready_i = 1'b1;
    tick();
    tick();
    present(rand_word(), 1'b0);
    bus.key_ready_i = 1'b1;
    tick();
    bus.key_ready_i = 1'b0;
    check("simul_level", DW'(bus.level_o), DW'(2));

    // Back-to-back stream wraps the pointers
    for (int i = 0; i < 10; i++) present(rand_word(), 1'b1);
    for (int i = 0; i < 5; i++) tick();

    // Randomized stream with occasional bad words
    last_gen = rand_word();
    for (int i = 0; i < 300; i++) begin
      if (last_acc || !bus.rnd_valid_i) begin
        r = $urandom_range(9, 0);
        case (r)
          0: w = '0;
          1: w = '1;
          2: w = last_gen;
          3: w = pc_word(90);
          default: w = rand_word();
        endcase
        last_gen = w;
        bus.rnd_data_i  = w;
        bus.rnd_valid_i = ($urandom_range(3, 0) != 0);
      end
      bus.key_ready_i = $urandom_range(1, 0);
      tick();
    end
    apply_reset();

    // Reset while a word is pending and the FIFO holds three words
    present(rand_word(), 1'b0);
    present(rand_word(), 1'b0);
    w3 = rand_word();
    present(w3, 1'b0);
    tick();
    present(rand_word(), 1'b0);
    check("pre_rst_level", DW'(bus.level_o), DW'(3));
    apply_reset();
    present(w3, 1'b0);
    tick();
    check("post_rst_valid", DW'(bus.key_valid_o), DW'(1));
    check("post_rst_key", bus.key_o, w3);

    // Consecutive failures raise the sticky alarm and flush the FIFO
    present('0, 1'b0);
    present(ones, 1'b0);
    present(c0f, 1'b0);
    present(c0f, 1'b0);
    present('0, 1'b0);
    present(ones, 1'b0);
    tick();
    check("alarm_set", DW'(bus.alarm_o), DW'(1));
    check("alarm_trng_en", DW'(bus.trng_en_o), DW'(0));
    check("alarm_key_valid", DW'(bus.key_valid_o), DW'(0));
    check("alarm_level", DW'(bus.level_o), DW'(0));
    bus.rnd_data_i  = rand_word();
    bus.rnd_valid_i = 1'b1;
    bus.key_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("alarm_ignore_level", DW'(bus.level_o), DW'(0));
    check("alarm_sticky", DW'(bus.alarm_o), DW'(1));
    apply_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
